// File: rtl/pctrl_multi.sv
// Parametrised serial packet receiver with address match and broadcast.
// Frames: start, address, opcode, data, stop; rx is retimed onto tx.
module pctrl_multi #(
    parameter int ADDR_W   = 8,
    parameter int OP_W     = 3,
    parameter int DATA_W   = 62,
    parameter bit BCAST_EN = 1'b1
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [ADDR_W-1:0] address,
    input  logic              rx,
    output logic              tx,
    output logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              bcast,
    output logic              frm_err,
    output logic              busy
);

    localparam int MAXAO = (ADDR_W > OP_W) ? ADDR_W : OP_W;
    localparam int MAXW  = (MAXAO > DATA_W) ? MAXAO : DATA_W;
    localparam int CW    = $clog2(MAXW + 1);

    localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] O_LAST = CW'(OP_W - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_STOP = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              bcast_q, bcast_d;
    logic              ferr_q, ferr_d;
    logic              tx_q;
    logic              is_bc, own, match;

    assign own   = (addr_q == address);
    assign is_bc = BCAST_EN && (addr_q == {ADDR_W{1'b1}});
    assign match = own || is_bc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        op_d     = op_q;
        dat_d    = dat_q;
        opcode_d = opcode_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        bcast_d  = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end
            end
            S_ADDR: begin
                addr_d = {addr_q[ADDR_W-2:0], rx};
                if (cnt_q == A_LAST) begin
                    state_d = S_OP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OP: begin
                op_d = {op_q[OP_W-2:0], rx};
                if (cnt_q == O_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                dat_d = {dat_q[DATA_W-2:0], rx};
                if (cnt_q == D_LAST) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                state_d = S_IDLE;
                // A bad stop bit is never taken as the next start bit.
                if (!rx) begin
                    ferr_d = 1'b1;
                end else if (match) begin
                    opcode_d = op_q;
                    data_d   = dat_q;
                    valid_d  = 1'b1;
                    bcast_d  = is_bc && !own;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            op_q     <= '0;
            dat_q    <= '0;
            opcode_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            bcast_q  <= 1'b0;
            ferr_q   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            dat_q    <= dat_d;
            opcode_q <= opcode_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            bcast_q  <= bcast_d;
            ferr_q   <= ferr_d;
            tx_q     <= rx;
        end
    end

    assign tx      = tx_q;
    assign opcode  = opcode_q;
    assign data    = data_q;
    assign valid   = valid_q;
    assign bcast   = bcast_q;
    assign frm_err = ferr_q;
    assign busy    = (state_q != S_IDLE);

endmodule
